// File: rtl/sram_arbiter.sv
// Serialises CPU (port A) and secondary-master (port B) transactions onto one held SRAM
// controller command, with fixed A priority, a B starvation guard and a completion timeout.
module sram_arbiter #(
  parameter int AW           = 18,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 63
) (
  input  logic          CLK0,
  input  logic          reset_n,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  output logic          a_ack,
  output logic          a_err,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata,
  output logic          b_ack,
  output logic          b_err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          grant_b
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
  // Counter value in the last BUSY cycle before the abort.
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [3:0]    streak, streak_nxt;
  logic [7:0]    tcnt, tcnt_nxt;
  logic [AW-1:0] mem_addr_nxt;
  logic [DW-1:0] mem_wdata_nxt;
  logic          mem_rd_nxt, mem_wr_nxt;
  logic [DW-1:0] a_rdata_nxt, b_rdata_nxt;
  logic          a_ack_nxt, b_ack_nxt, a_err_nxt, b_err_nxt;
  logic          busy_nxt, grant_b_nxt;
  logic          pick_b;
  logic          win_we;

  function automatic logic [3:0] streak_inc(input logic [3:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 4'd1;
  endfunction

  always_ff @(posedge CLK0) begin
    if (!reset_n) begin
      state     <= IDLE;
      streak    <= '0;
      tcnt      <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_err     <= 1'b0;
      b_err     <= 1'b0;
      busy      <= 1'b0;
      grant_b   <= 1'b0;
    end else begin
      state     <= state_nxt;
      streak    <= streak_nxt;
      tcnt      <= tcnt_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_rd    <= mem_rd_nxt;
      mem_wr    <= mem_wr_nxt;
      a_rdata   <= a_rdata_nxt;
      b_rdata   <= b_rdata_nxt;
      a_ack     <= a_ack_nxt;
      b_ack     <= b_ack_nxt;
      a_err     <= a_err_nxt;
      b_err     <= b_err_nxt;
      busy      <= busy_nxt;
      grant_b   <= grant_b_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    streak_nxt    = streak;
    tcnt_nxt      = tcnt;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    mem_rd_nxt    = mem_rd;
    mem_wr_nxt    = mem_wr;
    a_rdata_nxt   = a_rdata;
    b_rdata_nxt   = b_rdata;
    a_ack_nxt     = 1'b0;
    b_ack_nxt     = 1'b0;
    a_err_nxt     = 1'b0;
    b_err_nxt     = 1'b0;
    grant_b_nxt   = grant_b;
    pick_b        = 1'b0;
    win_we        = 1'b0;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          pick_b        = b_req && (!a_req || (streak == STREAK_MAX));
          win_we        = pick_b ? b_we : a_we;
          mem_addr_nxt  = pick_b ? b_addr : a_addr;
          mem_wdata_nxt = pick_b ? b_wdata : a_wdata;
          mem_rd_nxt    = ~win_we;
          mem_wr_nxt    = win_we;
          grant_b_nxt   = pick_b;
          tcnt_nxt      = '0;
          // Streak only grows while B is actually being passed over.
          if (pick_b || !b_req) streak_nxt = '0;
          else                  streak_nxt = streak_inc(streak);
          state_nxt     = BUSY;
        end
      end

      BUSY: begin
        tcnt_nxt = tcnt + 8'd1;
        if (mem_ready) begin
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          if (mem_rd) begin
            if (grant_b) b_rdata_nxt = mem_rdata;
            else         a_rdata_nxt = mem_rdata;
          end
          a_ack_nxt = ~grant_b;
          b_ack_nxt = grant_b;
          state_nxt = ACK;
        end else if (tcnt == TCNT_LAST) begin
          mem_rd_nxt = 1'b0;
          mem_wr_nxt = 1'b0;
          a_ack_nxt  = ~grant_b;
          b_ack_nxt  = grant_b;
          a_err_nxt  = ~grant_b;
          b_err_nxt  = grant_b;
          state_nxt  = ACK;
        end
      end

      ACK: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised scoreboard bench for sram_arbiter: a transaction-level arbitration model fills
// expected command/ack queues; a controller model and an ack monitor pop and compare them.
module tb_sram_arbiter;

  localparam int AW = 18;
  localparam int DW = 16;
  localparam int SL = 4;
  localparam int TO = 63;

  typedef logic [AW-1:0] addr_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;   // 0 = controller never answers
  } txn_t;

  typedef struct {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            delay;
  } cmd_t;

  typedef struct {
    logic          port;
    logic          err;
    logic [DW-1:0] a_rd;
    logic [DW-1:0] b_rd;
  } ack_t;

  logic          CLK0 = 1'b0;
  logic          reset_n;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr, mem_addr;
  logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_wdata, mem_rdata;
  logic          a_ack, a_err, b_ack, b_err;
  logic          mem_rd, mem_wr, mem_ready, busy, grant_b;

  txn_t a_list[$];
  txn_t b_list[$];
  cmd_t cmd_q[$];
  ack_t ack_q[$];

  logic [DW-1:0] sram    [addr_t];
  logic [DW-1:0] ref_mem [addr_t];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ready_cyc = 0;
  int cmd_start_cyc = 0;
  int spur_req = 0;

  int            m_streak = 0;
  logic [DW-1:0] m_ard = '0;
  logic [DW-1:0] m_brd = '0;

  sram_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .CLK0(CLK0), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rdata(a_rdata), .a_ack(a_ack), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rdata(b_rdata), .b_ack(b_ack), .b_err(b_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy), .grant_b(grant_b)
  );

  always #5 CLK0 = ~CLK0;
  always @(posedge CLK0) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return a[15:0] ^ 16'h3C5A;
  endfunction

  // Transaction-level reference: grant order from pending lists, memory as an array.
  task automatic predict();
    txn_t qa[$];
    txn_t qb[$];
    txn_t t;
    logic pb;
    logic er;
    qa = a_list;
    qb = b_list;
    while (qa.size() != 0 || qb.size() != 0) begin
      pb = (qb.size() != 0) && (qa.size() == 0 || m_streak == SL);
      if (pb)                 m_streak = 0;
      else if (qb.size() != 0) m_streak = (m_streak < SL) ? m_streak + 1 : SL;
      else                    m_streak = 0;
      t = pb ? qb.pop_front() : qa.pop_front();
      cmd_q.push_back('{pb, t.we, t.addr, t.wdata, t.delay});
      er = (t.delay == 0) || (t.delay > TO);
      if (!er) begin
        if (t.we) ref_mem[t.addr] = t.wdata;
        else if (pb) m_brd = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
        else         m_ard = ref_mem.exists(t.addr) ? ref_mem[t.addr] : dflt(t.addr);
      end
      ack_q.push_back('{pb, er, m_ard, m_brd});
    end
  endtask

  task automatic drive_ports();
    a_req = (a_list.size() != 0);
    b_req = (b_list.size() != 0);
    if (a_req) begin
      a_we = a_list[0].we; a_addr = a_list[0].addr; a_wdata = a_list[0].wdata;
    end
    if (b_req) begin
      b_we = b_list[0].we; b_addr = b_list[0].addr; b_wdata = b_list[0].wdata;
    end
  endtask

  task automatic run_batch();
    int budget;
    budget = 0;
    predict();
    drive_ports();
    @(posedge CLK0); #1;
    check("grant_latency", mem_rd | mem_wr, 1);
    forever begin
      if (a_ack && a_list.size() != 0) void'(a_list.pop_front());
      if (b_ack && b_list.size() != 0) void'(b_list.pop_front());
      drive_ports();
      if (a_list.size() == 0 && b_list.size() == 0) break;
      budget++;
      if (budget > 5000) begin
        check("batch_pending", a_list.size() + b_list.size(), 0);
        a_list.delete();
        b_list.delete();
        drive_ports();
        break;
      end
      @(posedge CLK0); #1;
    end
    repeat (2) @(posedge CLK0);
    #1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = ($urandom_range(0, 9) == 0) ? 18'h3FFFF : 18'h00120 + 18'($urandom_range(0, 7));
    t.wdata = 16'($urandom);
    t.delay = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
    return t;
  endfunction

  // SRAM controller model: answers each held command after its scripted delay.
  initial begin : ctrl
    bit   in_cmd;
    int   left;
    int   start;
    int   spur_done;
    cmd_t cur;
    in_cmd = 0; left = 0; start = 0; spur_done = 0;
    cur = '{1'b0, 1'b0, '0, '0, 1};
    mem_ready = 1'b0;
    mem_rdata = '0;
    sram[18'h00123] = 16'hBEEF;
    forever begin
      @(posedge CLK0); #1;
      mem_ready = 1'b0;
      if (mem_rd || mem_wr) begin
        if (!in_cmd) begin
          in_cmd = 1; start = cyc; cmd_start_cyc = cyc;
          check("cmd_expected", cmd_q.size() != 0, 1);
          if (cmd_q.size() != 0) cur = cmd_q.pop_front();
          else cur = '{grant_b, mem_wr, mem_addr, mem_wdata, 1};
          left = cur.delay;
          check("grant_port", grant_b, cur.port);
          check("mem_wr", mem_wr, cur.we);
          check("mem_rd", mem_rd, !cur.we);
          check("mem_addr", mem_addr, cur.addr);
          check("mem_wdata", mem_wdata, cur.wdata);
        end
        if (left == 1) begin
          mem_ready = 1'b1;
          ready_cyc = cyc;
          if (mem_rd) mem_rdata = sram.exists(mem_addr) ? sram[mem_addr] : dflt(mem_addr);
          else begin
            sram[mem_addr] = mem_wdata;
            mem_rdata = 16'hDEAD;
          end
          in_cmd = 0;
        end else if (left > 1) begin
          left--;
        end
      end else begin
        if (in_cmd && cur.delay == 0) check("timeout_busy_cycles", cyc - start, TO);
        in_cmd = 0;
        if (spur_req != spur_done) begin
          spur_done = spur_req;
          mem_ready = 1'b1;
          mem_rdata = 16'hDEAD;
        end
      end
    end
  end

  // Ack monitor: every ack must match the next scoreboard entry.
  initial begin : mon
    ack_t e;
    forever begin
      @(posedge CLK0); #1;
      if (a_ack || b_ack) begin
        check("single_ack", a_ack && b_ack, 0);
        check("ack_expected", ack_q.size() != 0, 1);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_port", b_ack, e.port);
          check("a_err", a_err, e.err && !e.port);
          check("b_err", b_err, e.err && e.port);
          check("a_rdata", a_rdata, e.a_rd);
          check("b_rdata", b_rdata, e.b_rd);
          if (e.err) check("timeout_ack_latency", cyc - cmd_start_cyc, TO);
          else       check("ack_latency", cyc - ready_cyc, 1);
        end
      end else if (a_err || b_err) begin
        check("err_without_ack", a_err | b_err, 0);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: bench did not finish (total=%0d)", total);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    ref_mem[18'h00123] = 16'hBEEF;
    repeat (3) @(posedge CLK0);
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_err", a_err, 0);
    check("rst_b_err", b_err, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_b", grant_b, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    reset_n = 1'b1;
    @(posedge CLK0); #1;

    // A read answered 2 cycles after mem_rd rises
    a_list.push_back('{1'b0, 18'h00123, 16'h7777, 3});
    run_batch();

    // B write to the top address
    b_list.push_back('{1'b1, 18'h3FFFF, 16'h00A5, 2});
    run_batch();
    check("grant_b_held", grant_b, 1);

    // Both ports saturated: starvation guard interleaves B
    for (int i = 0; i < 10; i++) a_list.push_back('{1'b1, 18'h00100 + 18'(i), 16'(i * 3), 1});
    for (int i = 0; i < 3; i++)  b_list.push_back('{1'b0, 18'h00100 + 18'(i), 16'h0, 1});
    run_batch();

    // Timeout, then ready arriving in the very last BUSY cycle
    a_list.push_back('{1'b0, 18'h00122, 16'h0, 0});
    run_batch();
    a_list.push_back('{1'b0, 18'h00123, 16'h0, TO});
    run_batch();

    // Reset in the middle of BUSY
    cmd_q.push_back('{1'b0, 1'b0, 18'h00055, 16'h1111, 50});
    a_req = 1; a_we = 0; a_addr = 18'h00055; a_wdata = 16'h1111;
    @(posedge CLK0); #1;
    check("pre_reset_busy", busy, 1);
    repeat (2) @(posedge CLK0);
    #1;
    reset_n = 1'b0;
    a_req = 0;
    @(posedge CLK0); #1;
    reset_n = 1'b1;
    m_streak = 0; m_ard = '0; m_brd = '0;
    check("midrst_mem_rd", mem_rd, 0);
    check("midrst_mem_wr", mem_wr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_a_rdata", a_rdata, 0);
    repeat (3) begin
      @(posedge CLK0); #1;
      check("midrst_no_ack", a_ack | b_ack, 0);
    end
    a_list.push_back('{1'b0, 18'h00055, 16'h0, 2});
    run_batch();

    // Spurious mem_ready while idle
    spur_req++;
    repeat (3) begin
      @(posedge CLK0); #1;
      check("spur_busy", busy, 0);
      check("spur_no_ack", a_ack | b_ack, 0);
    end
    check("spur_a_rdata", a_rdata, m_ard);
    check("spur_b_rdata", b_rdata, m_brd);

    for (int r = 0; r < 16; r++) begin
      int na;
      int nb;
      na = $urandom_range(0, 5);
      nb = $urandom_range(0, 5);
      if (na + nb == 0) na = 1;
      for (int i = 0; i < na; i++) a_list.push_back(rand_txn());
      for (int i = 0; i < nb; i++) b_list.push_back(rand_txn());
      run_batch();
    end

    repeat (3) @(posedge CLK0);
    #1;
    check("cmd_q_drained", cmd_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
